// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: single-cycle ops register in one cycle; MULTU/DIVU iterate ITER cycles into HI/LO.
// Define ALU_OVF_TRAP_EN to add the OVF port and zero the result on ADD/SUB signed overflow.
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_CTRL,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             STALL_IN,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             OUT_VALID,
    output logic             BUSY,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
`ifdef ALU_OVF_TRAP_EN
    ,
    output logic             OVF
`endif
);
    localparam int CW = $clog2(ITER);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_XOR   = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_MULTU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_MFHI  = 4'd13;
    localparam logic [3:0] OP_MFLO  = 4'd14;
    localparam logic [3:0] OP_LUI   = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             out_hold;
    logic             is_multi;
    logic             last_iter;
    logic [WIDTH-1:0] add_res;
    logic [WIDTH-1:0] sub_res;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] alu_res;

    assign IN_READY  = (state_q == S_IDLE) && !(valid_q && STALL_IN);
    assign accept    = IN_VALID && IN_READY;
    assign out_hold  = valid_q && STALL_IN;
    assign is_multi  = (ALU_CTRL == OP_MULTU) || (ALU_CTRL == OP_DIVU);
    assign last_iter = (cnt_q == CW'(ITER - 1));

    assign add_res = A + B;
    assign sub_res = A - B;
    assign shamt   = A[4:0];

    always_comb begin
        alu_res = '0;
        case (ALU_CTRL)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_ADD:  alu_res = add_res;
            OP_XOR:  alu_res = A ^ B;
            OP_NOR:  alu_res = ~(A | B);
            OP_SUB:  alu_res = sub_res;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL:  alu_res = B << shamt;
            OP_SRL:  alu_res = B >> shamt;
            OP_SRA:  alu_res = $signed(B) >>> shamt;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            OP_LUI:  alu_res = B << 16;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_OVF_TRAP_EN
    logic ovf_q, ovf_d;
    logic ovf_det;

    // Overflow when operand signs agree (B inverted for SUB) and the result sign flips.
    always_comb begin
        ovf_det = 1'b0;
        if (ALU_CTRL == OP_ADD) begin
            ovf_det = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
        end else if (ALU_CTRL == OP_SUB) begin
            ovf_det = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = ovf_det;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`endif

    // Shift-add multiply keeps {acc,work} as the running product; restoring divide keeps
    // remainder in acc and quotient in work, so DONE commits HI=acc, LO=work for both.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] rem_sub;

    assign mul_sum = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign rem_sh  = {acc_q, work_q[WIDTH-1]};
    assign div_ge  = (rem_sh >= {1'b0, opnd_q});
    assign rem_sub = rem_sh[WIDTH-1:0] - opnd_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept && (ALU_CTRL == OP_MULTU)) begin
                    state_d = S_MUL;
                    cnt_d   = '0;
                    acc_d   = '0;
                    work_d  = B;
                    opnd_d  = A;
                end else if (accept && (ALU_CTRL == OP_DIVU)) begin
                    state_d = S_DIV;
                    cnt_d   = '0;
                    acc_d   = '0;
                    work_d  = A;
                    opnd_d  = B;
                end
            end
            S_MUL: begin
                acc_d  = mul_sum[WIDTH:1];
                work_d = {mul_sum[0], work_q[WIDTH-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                acc_d  = div_ge ? rem_sub : rem_sh[WIDTH-1:0];
                work_d = {work_q[WIDTH-2:0], div_ge};
                cnt_d  = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!STALL_IN) begin
                    hi_d    = acc_q;
                    lo_d    = work_q;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (out_hold) begin
            valid_d = 1'b1;
        end else if (accept && !is_multi) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            valid_d  = 1'b1;
`ifdef ALU_OVF_TRAP_EN
            if (ovf_det) begin
                result_d = '0;
                zero_d   = 1'b1;
            end
`endif
        end else if ((state_q == S_DONE) && !STALL_IN) begin
            result_d = work_q;
            zero_d   = (work_q == '0);
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
        end
    end

    assign RESULT    = result_q;
    assign ZERO      = zero_q;
    assign OUT_VALID = valid_q;
    assign BUSY      = (state_q != S_IDLE);
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: directed vector table, multi-cycle corner sequences, randomized ops vs model.
module tb_alu_exec_stage;
    localparam int ITER = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_s, b_s;
    logic [3:0]  ctrl_s;
    logic        in_valid_s, stall_s;
    logic        in_ready, zero_w, out_valid, busy;
    logic [31:0] result, hi, lo;
`ifdef ALU_OVF_TRAP_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    alu_exec_stage #(.WIDTH(32), .ITER(ITER)) dut (
        .clk(clk),
        .rst(rst),
        .A(a_s),
        .B(b_s),
        .ALU_CTRL(ctrl_s),
        .IN_VALID(in_valid_s),
        .IN_READY(in_ready),
        .STALL_IN(stall_s),
        .RESULT(result),
        .ZERO(zero_w),
        .OUT_VALID(out_valid),
        .BUSY(busy),
        .HI(hi),
        .LO(lo)
`ifdef ALU_OVF_TRAP_EN
        ,
        .OVF(ovf)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return ~(a | b);
            4'd5:  return a - b;
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b << a[4:0];
            4'd9:  return b >> a[4:0];
            4'd10: return 32'($signed(b) >>> a[4:0]);
            4'd13: return m_hi;
            4'd14: return m_lo;
            4'd15: return b << 16;
            default: return 32'd0;
        endcase
    endfunction

    // Issue one op when ready, then check its result; optional stall after the result appears.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int stall_n);
        logic [31:0] exp_r, eh, el, held;
        logic [63:0] prod;
        logic        ov, ok;
        int          edges, guard;
        longint      s;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (!in_ready) begin
            check("ready_timeout", in_ready, 1);
            return;
        end
        ctrl_s = op; a_s = a; b_s = b; in_valid_s = 1'b1;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        if (op == 4'd11 || op == 4'd12) begin
            if (op == 4'd11) begin
                prod = {32'h0, a} * {32'h0, b};
                eh = prod[63:32]; el = prod[31:0];
            end else if (b == 0) begin
                eh = a; el = 32'hFFFF_FFFF;
            end else begin
                eh = a % b; el = a / b;
            end
            edges = 0; ok = 1'b1; held = result;
            while (!out_valid && edges < 200) begin
                if (busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
                if (edges == ITER && stall_n > 0) begin
                    stall_s = 1'b1;
                    repeat (stall_n) begin
                        @(posedge clk); #1; edges++;
                        if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0 || result !== held) ok = 1'b0;
                    end
                    stall_s = 1'b0;
                end
                @(posedge clk); #1; edges++;
            end
            check("multi_busy_ready", ok, 1);
            check("multi_latency", edges, ITER + 1 + stall_n);
            check("multi_hi", hi, eh);
            check("multi_lo", lo, el);
            check("multi_result", result, el);
            check("multi_zero", zero_w, (el == 0));
            check("multi_busy_clear", busy, 0);
`ifdef ALU_OVF_TRAP_EN
            check("multi_ovf", ovf, 0);
`endif
            m_hi = eh; m_lo = el;
        end else begin
            exp_r = model_op(op, a, b);
            ov = 1'b0;
`ifdef ALU_OVF_TRAP_EN
            if (op == 4'd2 || op == 4'd5) begin
                s = (op == 4'd2) ? longint'($signed(a)) + longint'($signed(b))
                                 : longint'($signed(a)) - longint'($signed(b));
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            if (ov) exp_r = 32'd0;
            check("op_ovf", ovf, ov);
`else
            s = 0;
`endif
            check($sformatf("op%0d_result", op), result, exp_r);
            check($sformatf("op%0d_zero", op), zero_w, (exp_r == 0));
            check($sformatf("op%0d_valid", op), out_valid, 1);
            if (stall_n > 0) begin
                ok = 1'b1;
                stall_s = 1'b1; in_valid_s = 1'b1; ctrl_s = 4'd3; a_s = ~a; b_s = b;
                #1;
                if (in_ready !== 1'b0) ok = 1'b0;
                repeat (stall_n) begin
                    @(posedge clk); #1;
                    if (out_valid !== 1'b1 || result !== exp_r || in_ready !== 1'b0) ok = 1'b0;
                end
                stall_s = 1'b0; in_valid_s = 1'b0;
                check("stall_freeze", ok, 1);
            end
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t vec[14];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec[0]  = '{4'd2,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        vec[1]  = '{4'd5,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000};
        vec[2]  = '{4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vec[3]  = '{4'd7,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vec[4]  = '{4'd10, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000};
        vec[5]  = '{4'd9,  32'h0000_0004, 32'h8000_0000, 32'h0800_0000};
        vec[6]  = '{4'd15, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000};
        vec[7]  = '{4'd0,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234};
        vec[8]  = '{4'd1,  32'hF0F0_0000, 32'h0F00_000F, 32'hFFF0_000F};
        vec[9]  = '{4'd3,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
        vec[10] = '{4'd4,  32'h0000_00FF, 32'h0000_FF00, 32'hFFFF_0000};
        vec[11] = '{4'd8,  32'h0000_001F, 32'h0000_0003, 32'h8000_0000};
        vec[12] = '{4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vec[13] = '{4'd5,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
`ifdef ALU_OVF_TRAP_EN
        vec[0].res = 32'h0;
`endif
        m_hi = 0; m_lo = 0;
        rst = 1'b1; a_s = 0; b_s = 0; ctrl_s = 0; in_valid_s = 0; stall_s = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_zero", zero_w, 1);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_ready", in_ready, 1);
`ifdef ALU_OVF_TRAP_EN
        check("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            ctrl_s = vec[i].op; a_s = vec[i].a; b_s = vec[i].b; in_valid_s = 1'b1;
            @(posedge clk); #1;
            check($sformatf("vec%0d_result", i), result, vec[i].res);
            check($sformatf("vec%0d_zero", i), zero_w, (vec[i].res == 0));
            check($sformatf("vec%0d_valid", i), out_valid, 1);
`ifdef ALU_OVF_TRAP_EN
            check($sformatf("vec%0d_ovf", i), ovf, (i == 0));
`endif
        end
        in_valid_s = 1'b0;
        @(posedge clk); #1;
        check("idle_valid_drop", out_valid, 0);
        check("idle_result_hold", result, 32'hFFFF_FFFF);

        do_op(4'd2, 32'd1, 32'd2, 2);
        do_op(4'd11, 32'hFFFF_FFFF, 32'd2, 0);
        check("mul_hi_fixed", hi, 32'h1);
        check("mul_lo_fixed", lo, 32'hFFFF_FFFE);
        do_op(4'd13, 32'd0, 32'd0, 0);
        do_op(4'd12, 32'd100, 32'd7, 0);
        check("div_lo_fixed", lo, 32'd14);
        check("div_hi_fixed", hi, 32'd2);
        do_op(4'd12, 32'd9, 32'd0, 3);
        check("div0_lo_fixed", lo, 32'hFFFF_FFFF);
        check("div0_hi_fixed", hi, 32'd9);
        do_op(4'd14, 32'd0, 32'd0, 0);

        // Abort a divide partway through with an asynchronous reset.
        ctrl_s = 4'd12; a_s = 32'd1000; b_s = 32'd3; in_valid_s = 1'b1;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_valid", out_valid, 0);
        check("abort_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = 0; m_lo = 0;
        do_op(4'd2, 32'd1, 32'd2, 0);
        check("post_abort_add", result, 32'd3);

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op;
            logic [31:0] ra, rb;
            int          st;
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (op == 4'd12 && $urandom_range(0, 3) == 0) rb = 32'd0;
            else if (op == 4'd12) rb = rb >> $urandom_range(0, 31);
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            do_op(op, ra, rb, st);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage ALU. Consumes operand A and the ALU operand-B mux output, and produces a registered result for the EX/MEM boundary.
- Single-cycle ops have 1-cycle latency.
- MULTU/DIVU run iteratively (32 cycles) into HI/LO and stall the upstream pipeline via IN_READY.

Parameters:
- WIDTH, 32, datapath width (only 32 is supported; shift amount uses bits [4:0]).
- ITER, 32, iterations for MULTU/DIVU (equals WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  32  operand A (rs value).
- B  input  32  operand B (output of the operand-B mux: rt or immediate).
- ALU_CTRL  input  4  operation select.
- IN_VALID  input  1  operands/op valid this cycle.
- IN_READY  output  1  stage can accept; transfer occurs when IN_VALID & IN_READY.
- STALL_IN  input  1  downstream hold; output register must not change while high.
- RESULT  output  32  registered result.
- ZERO  output  1  registered, RESULT==0.
- OUT_VALID  output  1  RESULT valid.
- BUSY  output  1  multi-cycle op in progress.
- HI  output  32  HI register.
- LO  output  32  LO register.
- OVF  output  1  signed overflow flag; present only with ALU_OVF_TRAP_EN.

Behaviour:
- Reset (asynchronous, active-high): RESULT=0, ZERO=1, OUT_VALID=0, BUSY=0, HI=0, LO=0, iteration counter=0, FSM=IDLE, OVF=0.
- ALU_CTRL encoding:
  - 0 AND; 1 OR; 2 ADD (wraps mod 2^32); 3 XOR; 4 NOR; 5 SUB (A-B).
  - 6 SLT (signed A<B → 1 else 0); 7 SLTU (unsigned).
  - 8 SLL (B<<A[4:0]); 9 SRL (B>>A[4:0] logical); 10 SRA (B>>>A[4:0] arithmetic).
  - 11 MULTU; 12 DIVU; 13 MFHI (RESULT=HI); 14 MFLO (RESULT=LO); 15 LUI (B<<16).
- IN_READY = (FSM==IDLE) & !(OUT_VALID & STALL_IN). Combinational, no dependence on IN_VALID.
- Single-cycle ops: accepted at edge N → RESULT/ZERO/OUT_VALID=1 at edge N+1.
- No accept and not stalled → OUT_VALID=0 next edge. RESULT holds its last value.
- STALL_IN=1 with OUT_VALID=1 → RESULT, ZERO, OUT_VALID frozen; nothing is accepted.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE→MUL on accepted MULTU; IDLE→DIV on accepted DIVU. Operands are latched and count=0.
  - MUL: shift-add, one bit per cycle; count increments each cycle.
  - DIV: restoring division, one quotient bit per cycle.
  - After ITER cycles (count==ITER-1) → DONE.
  - DONE: write HI/LO. MULTU: {HI,LO}=A*B (64-bit unsigned). DIVU: LO=A/B, HI=A%B. Assert OUT_VALID with RESULT=LO for one cycle → IDLE. If STALL_IN is high, remain in DONE.
- Accepted MULTU/DIVU at edge N → HI/LO updated and OUT_VALID=1 at edge N+ITER+1. BUSY=1 in MUL, DIV and DONE. IN_READY=0 throughout.
- DIVU with B==0: no exception, same latency. Result LO=0xFFFFFFFF, HI=A.
- MFHI/MFLO always read the committed HI/LO. Never issued during BUSY, because IN_READY=0.
- rst asserted mid-MUL/DIV: operation aborted immediately, all state returns to reset values, HI/LO=0.
- Datapath arithmetic uses no inferred `*` or `/` operators (iterative only).

Optional Feature:
- Macro: ALU_OVF_TRAP_EN.
- Defined:
  - OVF port exists. Registered with RESULT: 1 when ADD/SUB signed overflow occurs (operand signs match and result sign differs, for SUB using ~B).
  - On overflow, RESULT is written as 0 and ZERO=1; OUT_VALID still asserts.
  - OVF cleared on the next accepted op and on reset.
- Undefined: OVF port absent; ADD/SUB wrap silently.

Test Plan:
- Reset then ADD A=0x7FFFFFFF B=1 → next cycle RESULT=0x80000000, ZERO=0, OUT_VALID=1. With ALU_OVF_TRAP_EN: RESULT=0, OVF=1, ZERO=1.
- SUB A=5 B=5 then SLT A=0xFFFFFFFF B=1 back-to-back → RESULT=0, ZERO=1, then RESULT=1; SLTU with the same operands → 0.
- SRA A=4 B=0x80000000 → 0xF8000000. SRL → 0x08000000. LUI B=0x1234 → 0x12340000.
- MULTU A=0xFFFFFFFF B=2 at edge N → IN_READY=0 and BUSY=1 for N+1..N+33. At edge N+33: HI=1, LO=0xFFFFFFFE, OUT_VALID=1. Then MFHI → RESULT=1.
- DIVU A=100 B=7 → LO=14, HI=2. DIVU A=9 B=0 → LO=0xFFFFFFFF, HI=9. STALL_IN held 3 cycles at DONE → RESULT frozen and IN_READY=0 until release.
- rst pulsed at cycle 10 of DIVU → BUSY=0, HI=LO=0, OUT_VALID=0 immediately. Next ADD A=1 B=2 → RESULT=3.
